// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmitter that pops bytes from an upstream FIFO and
// sends each one as start bit, Width data bits LSB first, one stop bit.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line high, not busy; pops as soon as the FIFO reports data
//   FETCH | one cycle: capture the FIFO read data, drive the start bit next
//   START | start bit (low) for ClksPerBit cycles
//   DATA  | data bits, LSB first, ClksPerBit cycles each
//   STOP  | stop bit (high); final cycle may pop the next word back-to-back
module uart_tx_drain #(
  parameter int Width      = 8,
  parameter int ClksPerBit = 104
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_read_valid_i,
  output logic             fifo_read_req_o,
  input  logic [Width-1:0] fifo_data_i,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int BitW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(Width - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t          state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [BitW-1:0] bit_idx_q;
  logic [Width-1:0] shift_q;
  logic [Width-1:0] shift_next;
  logic            tx_q;
  logic            busy_q;
  logic            bit_done;
  logic            pop;

  // Last cycle of the current serial bit.
  assign bit_done   = (clk_cnt_q == CntLast);
  assign shift_next = shift_q >> 1;

  // Pop request: only when idle or on the final stop cycle, never in reset.
  always_comb begin
    pop = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: pop = fifo_read_valid_i;
        ST_STOP: pop = bit_done & fifo_read_valid_i;
        default: pop = 1'b0;
      endcase
    end
  end

  assign fifo_read_req_o = pop;
  assign tx_o            = tx_q;
  assign busy_o          = busy_q;

  // Frame sequencer: state, bit timing, shift register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q      <= 1'b1;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        // FIFO read data is only valid here, the cycle after the pop.
        ST_FETCH: begin
          shift_q   <= fifo_data_i;
          tx_q      <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          state_q   <= ST_START;
        end

        ST_START: begin
          if (bit_done) begin
            tx_q      <= shift_q[0];
            clk_cnt_q <= '0;
            state_q   <= ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == BitLast) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_next;
              tx_q      <= shift_next[0];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        // Line stays high into FETCH on a back-to-back pop.
        ST_STOP: begin
          if (bit_done) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            if (pop) begin
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO model plus a frame-timeline reference model.
module tb_uart_tx_drain;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int C2 = 104;
  localparam int FRAME_LEN = 1 + C * (W + 2);

  logic clk_i = 1'b0;
  logic rst_i;
  logic valid, req, tx, busy;
  logic [W-1:0] data;
  logic valid2, req2, tx2, busy2;
  logic [W-1:0] data2;

  always #5 clk_i = ~clk_i;

  uart_tx_drain #(.Width(W), .ClksPerBit(C)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_read_valid_i(valid),
    .fifo_read_req_o(req), .fifo_data_i(data), .tx_o(tx), .busy_o(busy));

  uart_tx_drain #(.Width(W), .ClksPerBit(C2)) dut_slow (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_read_valid_i(valid2),
    .fifo_read_req_o(req2), .fifo_data_i(data2), .tx_o(tx2), .busy_o(busy2));

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int mstart = -1;
  logic [W-1:0] mbyte;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  bit valid_en = 1'b0;
  logic s_tx, s_busy, s_req;
  logic cap_tx[0:127];
  logic cap_busy[0:127];
  logic cap_req[0:127];

  typedef struct {
    int   k;
    logic tx;
    logic busy;
    logic req;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected line level k cycles after the pop of byte b.
  function automatic logic line_bit(input int k, input logic [W-1:0] b);
    if (k <= 1) return 1'b1;
    if (k <= 1 + C) return 1'b0;
    if (k <= 1 + C * (W + 1)) return b[3'((k - 2 - C) / C)];
    return 1'b1;
  endfunction

  task automatic push(input logic [W-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // One clock cycle: check against the model at negedge, then serve the FIFO.
  task automatic step();
    int k;
    bit fin;
    logic etx, ebusy, ereq;
    @(negedge clk_i);
    s_tx = tx; s_busy = busy; s_req = req;
    if (rst_i) mstart = -1;
    k = (mstart >= 0) ? cyc - mstart : -1;
    fin = (mstart < 0) || (k == FRAME_LEN);
    etx = (mstart < 0) ? 1'b1 : line_bit(k, mbyte);
    ebusy = (mstart >= 0) && (k >= 1);
    ereq = fin && valid && !rst_i;
    chk("model_req", 32'(s_req), 32'(ereq));
    chk("model_tx", 32'(s_tx), 32'(etx));
    chk("model_busy", 32'(s_busy), 32'(ebusy));
    if (ereq) begin
      mstart = cyc;
      mbyte = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    end else if (fin) begin
      mstart = -1;
    end
    @(posedge clk_i);
    if (s_req && fifo_q.size() > 0) data = fifo_q.pop_front();
    #1;
    valid = valid_en && (fifo_q.size() > 0);
    cyc++;
  endtask

  task automatic run_capture(input int n);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_req) found = 1'b1;
    end
    chk("pop_seen", 32'(found), 32'(1));
    cap_tx[0] = s_tx; cap_busy[0] = s_busy; cap_req[0] = s_req;
    for (int k = 1; k <= n; k++) begin
      step();
      cap_tx[k] = s_tx; cap_busy[k] = s_busy; cap_req[k] = s_req;
    end
  endtask

  initial begin
    int cnt, e_n, bf;
    int e[0:15];
    bit found;
    logic prev;

    // 0xA5 frame, pop at k=0: bits LSB first 1,0,1,0,0,1,0,1.
    tbl.push_back('{0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{2, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{5, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{6, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{9, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{10, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{14, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{18, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{22, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{26, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{30, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{34, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{37, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{38, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{41, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{42, 1'b1, 1'b0, 1'b0});

    rst_i = 1'b1; data = '0; data2 = 8'h55; valid2 = 1'b0;

    // Reset held with data waiting: no pop until release, pop right after.
    valid_en = 1'b1;
    push(8'h5A);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("reset_req", 32'(req), 32'(0));
    chk("reset_tx", 32'(tx), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step();
    chk("first_pop_after_reset", 32'(s_req), 32'(1));
    for (int i = 0; i < FRAME_LEN + 2; i++) step();

    // Single 0xA5 frame against the fixed timing table.
    push(8'hA5);
    valid = 1'b1;
    run_capture(43);
    foreach (tbl[i]) begin
      chk($sformatf("a5_tx_k%0d", tbl[i].k), 32'(cap_tx[tbl[i].k]), 32'(tbl[i].tx));
      chk($sformatf("a5_busy_k%0d", tbl[i].k), 32'(cap_busy[tbl[i].k]), 32'(tbl[i].busy));
      chk($sformatf("a5_req_k%0d", tbl[i].k), 32'(cap_req[tbl[i].k]), 32'(tbl[i].req));
    end

    // Back-to-back 0x00 then 0xFF.
    push(8'h00);
    push(8'hFF);
    valid = 1'b1;
    run_capture(100);
    cnt = 0;
    for (int k = 0; k <= 100; k++) if (cap_req[k]) cnt++;
    chk("b2b_req_pulses", 32'(cnt), 32'(2));
    chk("b2b_second_pop_k41", 32'(cap_req[41]), 32'(1));
    chk("b2b_last_data_low_k37", 32'(cap_tx[37]), 32'(0));
    cnt = 0;
    for (int k = 38; k <= 60 && cap_tx[k]; k++) cnt++;
    chk("b2b_high_gap", 32'(cnt), 32'(5));
    chk("b2b_second_start_k43", 32'(cap_tx[43]), 32'(0));
    chk("b2b_idle_at_end", 32'(cap_busy[100]), 32'(0));

    // Long idle with an empty FIFO.
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (s_req || s_busy || !s_tx) cnt++;
    end
    chk("idle_200_violations", 32'(cnt), 32'(0));

    // Async reset in the middle of DATA; aborted byte must not be resent.
    push(8'h3C);
    push(8'h81);
    valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_req) found = 1'b1;
    end
    chk("abort_pop_seen", 32'(found), 32'(1));
    for (int i = 0; i < 15; i++) step();
    #3;
    rst_i = 1'b1;
    #1;
    chk("abort_tx_async", 32'(tx), 32'(1));
    chk("abort_busy_async", 32'(busy), 32'(0));
    chk("abort_req_async", 32'(req), 32'(0));
    for (int i = 0; i < 3; i++) step();
    rst_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      if (s_req) found = 1'b1;
    end
    chk("abort_repop", 32'(found), 32'(1));
    for (int i = 0; i < FRAME_LEN + 5; i++) step();
    chk("abort_fifo_drained", 32'(fifo_q.size()), 32'(0));
    chk("abort_model_drained", 32'(exp_q.size()), 32'(0));

    // Randomized traffic with random valid gating.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) push(8'($urandom));
      valid_en = ($urandom_range(0, 3) != 0);
      step();
    end
    valid_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (fifo_q.size() == 0 && mstart < 0) found = 1'b1;
    end
    chk("random_drain", 32'(found), 32'(1));

    // Slow instance: 0x55 at 104 clocks per bit.
    valid2 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (busy2) found = 1'b1;
    end
    valid2 = 1'b0;
    chk("slow_started", 32'(found), 32'(1));
    e_n = 0; bf = -1; prev = tx2;
    for (int n = 1; n <= 1300 && bf < 0; n++) begin
      step();
      if (tx2 !== prev && e_n < 16) begin
        e[e_n] = n;
        e_n++;
      end
      prev = tx2;
      if (!busy2) bf = n;
    end
    chk("slow_edge_count", 32'(e_n), 32'(10));
    if (e_n == 10) begin
      for (int i = 0; i < 9; i++) chk($sformatf("slow_bit%0d_len", i), 32'(e[i+1] - e[i]), 32'(C2));
      chk("slow_frame_len", 32'(bf - e[0]), 32'(10 * C2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
